// File: rtl/video_timing_monitor.sv
// Passive measurement of a video timing stream: frame geometry, sync lock,
// PAL/NTSC classification and loss-of-signal, all sampled on the pixel enable.
module video_timing_monitor #(
  parameter int HW            = 12,
  parameter int VW            = 10,
  parameter int TIMEOUT_LINES = 1000,
  parameter int PAL_LINES_MIN = 288
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hblank,
  input  logic          vblank,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [HW-1:0] hs_width,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          meas_valid,
  output logic          locked,
  output logic          is_pal,
  output logic          no_signal,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {SEARCH, FIRST, TRACK} state_t;

  localparam logic [HW-1:0] H_MAX     = '1;
  localparam logic [VW-1:0] V_MAX     = '1;
  localparam logic [VW-1:0] TIMEOUT_V = VW'(TIMEOUT_LINES);
  localparam logic [VW-1:0] PAL_V     = VW'(PAL_LINES_MIN);

  state_t        state, state_nxt;
  logic          hs_prev, vs_prev;
  logic [HW-1:0] h_cnt, h_total_cur, hs_cnt, hs_width_cur, act_cnt, act_max;
  logic [VW-1:0] line_cnt, vact_cnt;
  logic [HW-1:0] prev_h;
  logic [VW-1:0] prev_v;

  logic          hs_rise, hs_fall, vs_rise, active_px;
  logic          timeout_hit, h_match, v_close;
  logic          publish, frame_start, timeout;
  logic [HW-1:0] h_total_fold, hs_width_fold, act_max_fold;
  logic [VW-1:0] line_fold, vact_fold;
  logic [VW:0]   v_new, v_old;

  assign hs_rise   = ce_pix & hsync & ~hs_prev;
  assign hs_fall   = ce_pix & ~hsync & hs_prev;
  assign vs_rise   = ce_pix & vsync & ~vs_prev;
  assign active_px = ~hblank & ~vblank;

  // Frame values as they stand after this pixel's hsync processing, so a line
  // ending on the same pixel as a vsync rise is credited to the ending frame.
  always_comb begin
    h_total_fold  = hs_rise ? h_cnt : h_total_cur;
    hs_width_fold = hs_fall ? hs_cnt : hs_width_cur;
    act_max_fold  = (hs_rise && act_cnt > act_max) ? act_cnt : act_max;
    line_fold     = (hs_rise && line_cnt != V_MAX) ? line_cnt + 1'b1 : line_cnt;
    vact_fold     = (hs_rise && act_cnt != '0 && vact_cnt != V_MAX)
                    ? vact_cnt + 1'b1 : vact_cnt;
  end

  assign timeout_hit = (line_cnt >= TIMEOUT_V) || (h_cnt == H_MAX);
  assign h_match     = (h_total_fold == prev_h);
  assign v_new       = {1'b0, line_fold};
  assign v_old       = {1'b0, prev_v};
  // One line of slack lets interlaced sources alternate odd/even frame lengths.
  assign v_close     = (v_new == v_old) || (v_new == v_old + 1'b1) ||
                       (v_old == v_new + 1'b1);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nxt   = state;
    publish     = 1'b0;
    frame_start = 1'b0;
    timeout     = 1'b0;
    if (ce_pix) begin
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            frame_start = 1'b1;
            state_nxt   = FIRST;
          end
        end
        FIRST, TRACK: begin
          if (vs_rise) begin
            publish     = 1'b1;
            frame_start = 1'b1;
            state_nxt   = TRACK;
          end else if (timeout_hit) begin
            timeout   = 1'b1;
            state_nxt = SEARCH;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEARCH;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev      <= 1'b0;
      vs_prev      <= 1'b0;
      h_cnt        <= '0;
      h_total_cur  <= '0;
      hs_cnt       <= '0;
      hs_width_cur <= '0;
      act_cnt      <= '0;
    end else if (ce_pix) begin
      hs_prev <= hsync;
      vs_prev <= vsync;

      if (hs_rise) begin
        h_total_cur <= h_cnt;
        h_cnt       <= HW'(1);
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + 1'b1;
      end

      if (hs_rise)                      hs_cnt <= HW'(1);
      else if (hsync && hs_cnt != H_MAX) hs_cnt <= hs_cnt + 1'b1;
      if (hs_fall) hs_width_cur <= hs_cnt;

      if (hs_rise)                           act_cnt <= active_px ? HW'(1) : '0;
      else if (active_px && act_cnt != H_MAX) act_cnt <= act_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= '0;
      act_max  <= '0;
      vact_cnt <= '0;
    end else if (frame_start) begin
      line_cnt <= '0;
      act_max  <= '0;
      vact_cnt <= '0;
    end else if (hs_rise) begin
      line_cnt <= line_fold;
      act_max  <= act_max_fold;
      vact_cnt <= vact_fold;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total    <= '0;
      h_active   <= '0;
      hs_width   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      is_pal     <= 1'b0;
      no_signal  <= 1'b0;
      frame_cnt  <= '0;
      prev_h     <= '0;
      prev_v     <= '0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        h_total   <= h_total_fold;
        hs_width  <= hs_width_fold;
        h_active  <= act_max_fold;
        v_total   <= line_fold;
        v_active  <= vact_fold;
        is_pal    <= (line_fold >= PAL_V);
        frame_cnt <= frame_cnt + 1'b1;
        no_signal <= 1'b0;
        if (state == TRACK) locked <= h_match && v_close;
        prev_h    <= h_total_fold;
        prev_v    <= line_fold;
      end else if (timeout) begin
        h_total   <= '0;
        h_active  <= '0;
        hs_width  <= '0;
        v_total   <= '0;
        v_active  <= '0;
        is_pal    <= 1'b0;
        locked    <= 1'b0;
        no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboarded bench for video_timing_monitor: directed video streams push the
// publishes they should cause; a monitor pops and compares on meas_valid.
module tb_video_timing_monitor;

  localparam int HW        = 12;
  localparam int VW        = 10;
  localparam int H_TOT     = 8;
  localparam int HS_W      = 2;
  localparam int ACT_START = 3;
  localparam int ACT_LEN   = 4;
  localparam int V_ACT     = 240;
  localparam int VS_OFF    = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce_pix, hsync, vsync, hblank, vblank;
  logic [HW-1:0] h_total, h_active, hs_width;
  logic [VW-1:0] v_total, v_active;
  logic          meas_valid, locked, is_pal, no_signal;
  logic [15:0]   frame_cnt;

  typedef struct {
    int v_total;
    bit is_pal;
    bit locked;
    int frame_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   ce_div = 1;

  video_timing_monitor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank),
    .h_total   (h_total),
    .h_active  (h_active),
    .hs_width  (hs_width),
    .v_total   (v_total),
    .v_active  (v_active),
    .meas_valid(meas_valid),
    .locked    (locked),
    .is_pal    (is_pal),
    .no_signal (no_signal),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_publish(input int vt, input bit pal, input bit lock, input int fc);
    exp_t e;
    e.v_total   = vt;
    e.is_pal    = pal;
    e.locked    = lock;
    e.frame_cnt = fc;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag, input int fc, input bit ns);
    check({tag, ":h_total"},    32'(h_total),    0);
    check({tag, ":h_active"},   32'(h_active),   0);
    check({tag, ":hs_width"},   32'(hs_width),   0);
    check({tag, ":v_total"},    32'(v_total),    0);
    check({tag, ":v_active"},   32'(v_active),   0);
    check({tag, ":is_pal"},     32'(is_pal),     0);
    check({tag, ":locked"},     32'(locked),     0);
    check({tag, ":no_signal"},  32'(no_signal),  32'(ns));
    check({tag, ":frame_cnt"},  32'(frame_cnt),  32'(fc));
  endtask

  // One enabled pixel followed by ce_div-1 disabled clocks carrying junk inputs.
  task automatic tick(input logic hs, input logic vs, input logic hb, input logic vb);
    hsync  = hs;
    vsync  = vs;
    hblank = hb;
    vblank = vb;
    ce_pix = 1'b1;
    @(negedge clk);
    for (int k = 1; k < ce_div; k++) begin
      ce_pix = 1'b0;
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      hblank = 1'($urandom);
      vblank = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // Active picture is lines 20..259; vsync is high for three lines from vs_off.
  task automatic gen_frame(input int lines, input bit vs_en, input int vs_off,
                           input int stop_line);
    int   idx;
    logic hs, vs, hb, vb;
    for (int l = 0; l < lines && l != stop_line; l++) begin
      for (int p = 0; p < H_TOT; p++) begin
        idx = l * H_TOT + p;
        hs  = (p < HS_W);
        vs  = vs_en && idx >= vs_off && idx < vs_off + 3 * H_TOT;
        vb  = !(l >= 20 && l <= 259);
        hb  = !(p >= ACT_START && p < ACT_START + ACT_LEN);
        tick(hs, vs, hb, vb);
      end
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_publish", 32'(meas_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pub:h_total",   32'(h_total),   H_TOT);
        check("pub:hs_width",  32'(hs_width),  HS_W);
        check("pub:h_active",  32'(h_active),  ACT_LEN);
        check("pub:v_total",   32'(v_total),   mon_e.v_total);
        check("pub:v_active",  32'(v_active),  V_ACT);
        check("pub:is_pal",    32'(is_pal),    32'(mon_e.is_pal));
        check("pub:locked",    32'(locked),    32'(mon_e.locked));
        check("pub:no_signal", 32'(no_signal), 0);
        check("pub:frame_cnt", 32'(frame_cnt), mon_e.frame_cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    hblank  = 1'b1;
    vblank  = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset", 0, 1'b0);
    check("reset:meas_valid", 32'(meas_valid), 0);
    reset_n = 1'b1;

    // NTSC 262 lines: first publish ends frame 2, lock on the next.
    gen_frame(262, 1'b1, VS_OFF, -1);
    expect_publish(262, 1'b0, 1'b0, 1);
    gen_frame(262, 1'b1, VS_OFF, -1);
    expect_publish(262, 1'b0, 1'b1, 2);
    gen_frame(262, 1'b1, VS_OFF, -1);
    check("ntsc:pending", exp_q.size(), 0);

    // PAL 312 lines: lock drops on the length change, then recovers.
    expect_publish(262, 1'b0, 1'b1, 3);
    gen_frame(312, 1'b1, VS_OFF, -1);
    expect_publish(312, 1'b1, 1'b0, 4);
    gen_frame(312, 1'b1, VS_OFF, -1);
    expect_publish(312, 1'b1, 1'b1, 5);
    gen_frame(312, 1'b1, VS_OFF, -1);

    // Interlace 263/262 holds lock; a jump to 270 breaks it for one frame.
    expect_publish(312, 1'b1, 1'b1, 6);
    gen_frame(263, 1'b1, VS_OFF, -1);
    expect_publish(263, 1'b0, 1'b0, 7);
    gen_frame(262, 1'b1, VS_OFF, -1);
    expect_publish(262, 1'b0, 1'b1, 8);
    gen_frame(263, 1'b1, VS_OFF, -1);
    expect_publish(263, 1'b0, 1'b1, 9);
    gen_frame(270, 1'b1, VS_OFF, -1);
    expect_publish(270, 1'b0, 1'b0, 10);
    gen_frame(270, 1'b1, VS_OFF, -1);
    expect_publish(270, 1'b0, 1'b1, 11);
    gen_frame(270, 1'b1, VS_OFF, -1);
    check("interlace:pending", exp_q.size(), 0);

    // Vsync stops: 1000 lines after the last rise the monitor gives up.
    gen_frame(740, 1'b0, 0, -1);
    check_idle("timeout", 11, 1'b1);

    // Restart: one rise is not enough to clear no_signal, the second publishes.
    gen_frame(262, 1'b1, VS_OFF, -1);
    check("restart:no_signal_after_one_rise", 32'(no_signal), 1);
    check("restart:frame_cnt_held", 32'(frame_cnt), 11);
    expect_publish(262, 1'b0, 1'b0, 12);
    gen_frame(262, 1'b1, VS_OFF, -1);

    // Hsync and vsync rising on the same pixel.
    expect_publish(262, 1'b0, 1'b1, 13);
    gen_frame(262, 1'b1, 0, -1);
    expect_publish(262, 1'b0, 1'b1, 14);
    gen_frame(262, 1'b1, 0, -1);
    expect_publish(262, 1'b0, 1'b1, 15);
    gen_frame(262, 1'b1, 0, -1);
    check("coincident:pending", exp_q.size(), 0);

    // Gated pixel enable with a mid-frame asynchronous reset.
    ce_div = 4;
    expect_publish(262, 1'b0, 1'b1, 16);
    gen_frame(262, 1'b1, 0, 100);
    check("gated:locked_before_reset", 32'(locked), 1);
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset", 0, 1'b0);
    check("async_reset:meas_valid", 32'(meas_valid), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    gen_frame(262, 1'b1, 0, -1);
    check("gated:frame_cnt_after_one_rise", 32'(frame_cnt), 0);
    expect_publish(262, 1'b0, 1'b0, 1);
    gen_frame(262, 1'b1, 0, 10);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Sink-side counterpart of the core's video output: consumes the core's HSync/VSync/HBlank/VBlank timing on the pixel enable and measures it.
- Reports measured frame geometry, sync lock, PAL/NTSC classification and loss of signal. Used for the OSD info line and as a bench checker.
- Sits on clk_sys beside the core's video outputs. Purely observational; it drives no video.

Parameters:
- HW, 12, width of horizontal counters (pixels per line).
- VW, 10, width of vertical counters (lines per frame).
- TIMEOUT_LINES, 1000, lines without a VSync rise before no_signal is declared.
- PAL_LINES_MIN, 288, a v_total at or above this value is classified as PAL.

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  asynchronous, active-low reset.
- ce_pix  in  1  pixel enable; all sampling and counting occurs only on clk edges with ce_pix=1.
- hsync  in  1  horizontal sync, active high.
- vsync  in  1  vertical sync, active high.
- hblank  in  1  horizontal blanking.
- vblank  in  1  vertical blanking.
- h_total  out  HW  ce_pix periods per line (last complete line of the frame).
- h_active  out  HW  maximum count of active pixels (hblank=0 and vblank=0) in any line of the frame.
- hs_width  out  HW  HSync high width, in ce_pix periods, of the last line.
- v_total  out  VW  lines per frame.
- v_active  out  VW  lines in the frame containing at least one active pixel.
- meas_valid  out  1  one-clk pulse when the outputs update.
- locked  out  1  timing stable.
- is_pal  out  1  v_total >= PAL_LINES_MIN.
- no_signal  out  1  sync lost.
- frame_cnt  out  16  count of published frames; wraps.

Behaviour:
- Reset (async assert, sync-release use): all outputs 0, all counters 0, state SEARCH.
- Edge detect: register hsync and vsync on ce_pix. A rise is input=1 and previous=0, both sampled on ce_pix.
- h_cnt, on each ce_pix:
  - On an hsync rise: h_total_cur<=h_cnt, h_cnt<=1.
  - Otherwise: h_cnt+1, saturating at all-ones.
- hs_cnt: counts ce_pix while hsync=1; cleared on an hsync rise (the rise counts as 1). On the hsync fall it latches to hs_width_cur.
- act_cnt: counts ce_pix with hblank=0 and vblank=0, saturating; cleared on an hsync rise. On an hsync rise:
  - act_max<=max(act_max, act_cnt).
  - If act_cnt!=0, vact_cnt increments.
- line_cnt: increments on each hsync rise, saturating.
- hsync and vsync rise on the same ce_pix: hsync processing first. The ending line counts into the ending frame; the new frame starts with line_cnt=0, act_max=0, vact_cnt=0.
- States:
  - SEARCH: wait for a vsync rise. Then clear the frame counters and go to FIRST. No publish.
  - FIRST: on a vsync rise, publish the frame, store it as prev and go to TRACK. locked stays 0.
  - TRACK: on each vsync rise, publish. Then:
    - locked<=1 if h_total equals prev and |v_total-prev|<=1 (interlace tolerance).
    - Otherwise locked<=0.
    - Update prev.
- Publish, in the same clk as the vsync-rise ce_pix:
  - h_total<=h_total_cur, hs_width<=hs_width_cur, h_active<=act_max, v_total<=line_cnt, v_active<=vact_cnt.
  - is_pal<=(line_cnt>=PAL_LINES_MIN), frame_cnt+1, no_signal<=0.
  - meas_valid is high for exactly that one clk. Outputs are registered and hold until the next publish.
- Timeout, in FIRST or TRACK: line_cnt reaches TIMEOUT_LINES, or h_cnt saturates.
  - no_signal<=1, locked<=0, state SEARCH.
  - Measurement outputs are cleared to 0; frame_cnt holds.
  - no_signal clears at the next publish.
- ce_pix=0: no state changes; input changes between enables are ignored.
- Mid-frame reset: the partial frame is discarded, and no publish occurs until the SEARCH→FIRST→publish sequence completes.

Test Plan:
- Timing of 400 ce/line, hsync width 32, 320 active pixels on lines 20..259, 262 lines/frame, 3 frames. Expected: first meas_valid at the end of frame 2 with h_total=400, hs_width=32, h_active=320, v_total=262, v_active=240, is_pal=0, locked=0. After frame 3: locked=1, frame_cnt=2.
- Same timing with 312 lines/frame. Expected: v_total=312, is_pal=1.
- Interlace, alternating 262/263 lines. Expected: locked stays 1. Then switch to 270 lines: locked drops to 0 on that publish and returns to 1 one frame later.
- Stop vsync while hsync continues. Expected: no_signal=1 and locked=0 after 1000 lines, outputs 0, frame_cnt unchanged. Restart vsync: no_signal clears after two vsync rises.
- hsync and vsync rising on the same ce_pix. Expected: v_total includes the ending line, and the next frame's count starts at 0; v_total stays 262 across frames.
- Assert reset_n=0 mid-frame with ce_pix gated to 1 in 4 clks. Expected: all outputs 0 immediately, asynchronously; after release, the first meas_valid appears only after two vsync rises; counts are unchanged versus ce_pix=1 always.
